uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_tick_gen.sv | 32 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Frame constants and state encoding shared by the UART receiver and the future transmitter.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    localparam int CLK_FREQ_DEF = 100000000;
    localparam int BAUD_DEF     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // System clocks per oversampling tick (integer division).
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    localparam int DIV_DEF = calc_div(CLK_FREQ_DEF, BAUD_DEF);

endpackage

// File: rtl/uart_rx_if.sv
// Byte-level output side of the UART receiver.
// RX_VALID is a level: it rises when a byte completes and stays high until the
// consumer holds RX_ACK for one edge; RX_ACK while RX_VALID is low is ignored.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] RX_DATA;
    logic                 RX_VALID;
    logic                 RX_ACK;
    logic                 FRAME_ERR;
    logic                 OVERRUN;

    modport master (
        output RX_DATA,
        output RX_VALID,
        output FRAME_ERR,
        output OVERRUN,
        input  RX_ACK
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        input  FRAME_ERR,
        input  OVERRUN,
        output RX_ACK
    );

endinterface

// File: rtl/uart_tick_gen.sv
// Free-running divide-by-DIV counter producing a one-cycle tick; clr restarts the phase.
module uart_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: RXD synchronizer, oversampled bit FSM and a valid/ack output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        RXD,
    uart_rx_if.master   rx_if,
    output uart_state_e state_dbg
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 hist_q, hist_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BIW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic tick;
    logic tick_clr;
    logic fall;

    uart_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (CLK100MHZ),
        .rst  (RST),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign sync1_d = RXD;
    assign sync2_d = sync1_q;
    assign hist_d  = sync2_q;
    assign fall    = hist_q && !sync2_q;

    // Tick phase is restarted on the start edge so sampling lands mid-bit.
    assign tick_clr = (state_q == ST_IDLE) && fall;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_if.RX_ACK;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TCW'(1);
                    if (tick_cnt_q == TCW'(HALF_BIT - 1)) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = sync2_q ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TCW'(1);
                    if (tick_cnt_q == TCW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        shift_d    = {sync2_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIW'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIW'(1);
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TCW'(1);
                    if (tick_cnt_q == TCW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        if (sync2_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            overrun_d  = rx_valid_q && !rx_if.RX_ACK;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.RX_DATA   = rx_data_q;
    assign rx_if.RX_VALID  = rx_valid_q;
    assign rx_if.FRAME_ERR = frame_err_q;
    assign rx_if.OVERRUN   = overrun_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx, run with a fast baud divider so whole frames stay short.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BAUD     = 9600;
    localparam int TB_DIV   = 4;
    localparam int CLK_FREQ = BAUD * OVERSAMPLE * TB_DIV;
    localparam int BIT      = OVERSAMPLE * TB_DIV;
    localparam int LAT      = (BIT * 19) / 2;   // 9.5 bit periods
    localparam int LAT_EDGE = LAT + 3;          // plus synchronizer and edge detect

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         exp_ferr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    uart_state_e state_dbg;
    uart_rx_if   u_if();

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int   ferr_seen     = 0;
    int   ovr_seen      = 0;
    int   rise_cnt      = 0;
    int   last_rise_cyc = 0;
    int   frame_start   = 0;
    logic valid_prev    = 1'b0;
    logic ack_prev      = 1'b0;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .RXD       (rxd),
        .rx_if     (u_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor: collects delivered bytes and pulses ----------------
    // A new byte is presented when VALID rises, when it stays high across an
    // acknowledged edge, or when OVERRUN reports a replacement.
    always @(negedge clk) begin
        if (u_if.RX_VALID && (!valid_prev || ack_prev || u_if.OVERRUN)) begin
            got_q.push_back(u_if.RX_DATA);
        end
        if (u_if.RX_VALID && !valid_prev) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        if (u_if.FRAME_ERR) ferr_seen <= ferr_seen + 1;
        if (u_if.OVERRUN)   ovr_seen  <= ovr_seen + 1;
        valid_prev <= u_if.RX_VALID;
        ack_prev   <= u_if.RX_ACK;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests_run++;
        if (act < lo || act > hi) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic score(input string name);
        logic [7:0] g;
        logic [7:0] e;
        check({name, " byte count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({name, " byte"}, {24'h0, g}, {24'h0, e});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks (all start and end just after a rising edge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        wait_cycles(BIT);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        frame_start = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(stop);
        rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        u_if.RX_ACK = 1'b1;
        wait_cycles(1);
        u_if.RX_ACK = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            wait_cycles(1);
            k++;
        end
        check({name, " arrived in time"}, (got_q.size() >= n), 1);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];

    initial begin
        int ferr0, ovr0, rise0, exp_ferr;
        logic [7:0] d;
        logic stop;
        int gap;

        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        vecs[3] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1};
        vecs[4] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        vecs[5] = '{data: 8'hAA, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1};

        u_if.RX_ACK = 1'b0;
        rxd = 1'b1;
        rst = 1'b1;
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(3);

        // reset state
        check("reset RX_DATA", {24'h0, u_if.RX_DATA}, 32'h0);
        check("reset RX_VALID", u_if.RX_VALID, 1'b0);
        check("reset FRAME_ERR", u_if.FRAME_ERR, 1'b0);
        check("reset OVERRUN", u_if.OVERRUN, 1'b0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));

        // 0xA5 with latency measurement
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check_range("latency A5", last_rise_cyc - frame_start, LAT - TB_DIV, LAT + 4 + TB_DIV);
        check("A5 RX_DATA", {24'h0, u_if.RX_DATA}, 32'hA5);
        score("A5");
        check("A5 no FRAME_ERR", ferr_seen, 0);
        check("A5 no OVERRUN", ovr_seen, 0);
        pulse_ack();
        check("A5 ack clears VALID", u_if.RX_VALID, 1'b0);
        idle_bits(1);

        // short low glitch is rejected, then 0x3C
        rise0 = rise_cnt;
        rxd = 1'b0;
        wait_cycles(TB_DIV * 4 + TB_DIV / 2);
        rxd = 1'b1;
        wait_cycles(2 * BIT);
        check("glitch back to IDLE", 32'(state_dbg), 32'(ST_IDLE));
        check("glitch no VALID", rise_cnt, rise0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        score("after glitch");
        pulse_ack();
        idle_bits(1);

        // framing error followed by a long break, then 0x3C
        ferr0 = ferr_seen;
        rise0 = rise_cnt;
        send_frame(8'h5A, 1'b0);
        rxd = 1'b0;
        wait_cycles(20 * BIT);
        check("break holds BREAK state", 32'(state_dbg), 32'(ST_BREAK));
        rxd = 1'b1;
        idle_bits(1);
        check("break FRAME_ERR pulses", ferr_seen - ferr0, 1);
        check("break no VALID", rise_cnt, rise0);
        check("break RX_DATA kept", {24'h0, u_if.RX_DATA}, 32'h3C);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        score("after break");
        pulse_ack();
        idle_bits(1);

        // back-to-back without ack: overrun
        ovr0 = ovr_seen;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun pulse count", ovr_seen - ovr0, 1);
        check("overrun VALID held", u_if.RX_VALID, 1'b1);
        check("overrun RX_DATA", {24'h0, u_if.RX_DATA}, 32'h22);
        score("overrun");
        pulse_ack();
        idle_bits(1);

        // ack coincident with completion: no overrun
        ovr0 = ovr_seen;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(8'h33, 1'b1);
        fork
            send_frame(8'h44, 1'b1);
            begin
                wait_cycles(LAT_EDGE - 1);
                pulse_ack();
            end
        join
        idle_bits(1);
        check("coincident ack no OVERRUN", ovr_seen - ovr0, 0);
        check("coincident ack VALID", u_if.RX_VALID, 1'b1);
        check("coincident ack RX_DATA", {24'h0, u_if.RX_DATA}, 32'h44);
        score("coincident");

        // reset during data bit 4 of 0xFF
        rise0 = rise_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        rxd = 1'b1;
        wait_cycles(BIT / 2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("midframe reset RX_DATA", {24'h0, u_if.RX_DATA}, 32'h0);
        check("midframe reset RX_VALID", u_if.RX_VALID, 1'b0);
        check("midframe reset FRAME_ERR", u_if.FRAME_ERR, 1'b0);
        check("midframe reset OVERRUN", u_if.OVERRUN, 1'b0);
        wait_cycles(BIT - BIT / 2);
        idle_bits(6);
        check("midframe reset no frame", rise_cnt, rise0);
        score("midframe reset");
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        score("after reset");
        pulse_ack();
        idle_bits(1);

        // back-to-back 0x00 / 0xFF, each acked 10 clocks after VALID
        ferr0 = ferr_seen;
        ovr0  = ovr_seen;
        rise0 = rise_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_got(k + 1, 12 * BIT, "b2b");
                    wait_cycles(10);
                    pulse_ack();
                end
            end
        join
        idle_bits(1);
        check("b2b VALID rises", rise_cnt - rise0, 2);
        check("b2b no FRAME_ERR", ferr_seen - ferr0, 0);
        check("b2b no OVERRUN", ovr_seen - ovr0, 0);
        check("b2b VALID cleared", u_if.RX_VALID, 1'b0);
        score("b2b");

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            ferr0 = ferr_seen;
            if (vecs[v].exp_valid) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop);
            idle_bits(2);
            check($sformatf("vec%0d VALID", v), u_if.RX_VALID, vecs[v].exp_valid);
            check($sformatf("vec%0d FRAME_ERR", v), ferr_seen - ferr0, vecs[v].exp_ferr);
            score($sformatf("vec%0d", v));
            if (u_if.RX_VALID) pulse_ack();
        end

        // randomized frames against the reference model
        ferr0    = ferr_seen;
        ovr0     = ovr_seen;
        exp_ferr = 0;
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 2);
            if (stop) exp_q.push_back(d);
            else begin
                exp_ferr++;
                if (gap == 0) gap = 1;
            end
            send_frame(d, stop);
            score($sformatf("rand%0d", n));
            if (stop) begin
                wait_cycles($urandom_range(0, 20));
                pulse_ack();
            end
            idle_bits(gap);
        end
        idle_bits(1);
        check("random FRAME_ERR count", ferr_seen - ferr0, exp_ferr);
        check("random no OVERRUN", ovr_seen - ovr0, 0);
        check("random VALID idle", u_if.RX_VALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
